// File: rtl/pipe_ctrl_unit_if.sv
// Decode/control bus between the D-stage control unit and the rest of the 5-stage pipeline.
interface pipe_ctrl_unit_if;
  logic [31:0] instr_d;
  logic        flush_e;

  logic        branch_d;
  logic        bne_d;
  logic        jump_d;
  logic        jr_d;
  logic        illegal_d;
  logic        md_stall_d;

  logic        reg_dst_e;
  logic        alu_src_e;
  logic        zext_e;
  logic [3:0]  alu_ctrl_e;
  logic        shamt_sel_e;
  logic [1:0]  md_op_e;
  logic        md_start_e;
  logic        jal_e;
  logic [1:0]  mf_hilo_e;

  logic        we_dm_m;
  logic        we_reg_m;
  logic        dm2reg_m;
  logic        we_reg_w;
  logic        dm2reg_w;
  logic        md_busy;

  modport master (
    output instr_d, flush_e,
    input  branch_d, bne_d, jump_d, jr_d, illegal_d, md_stall_d,
    input  reg_dst_e, alu_src_e, zext_e, alu_ctrl_e, shamt_sel_e, md_op_e, md_start_e,
    input  jal_e, mf_hilo_e, we_dm_m, we_reg_m, dm2reg_m, we_reg_w, dm2reg_w, md_busy
  );

  modport slave (
    input  instr_d, flush_e,
    output branch_d, bne_d, jump_d, jr_d, illegal_d, md_stall_d,
    output reg_dst_e, alu_src_e, zext_e, alu_ctrl_e, shamt_sel_e, md_op_e, md_start_e,
    output jal_e, mf_hilo_e, we_dm_m, we_reg_m, dm2reg_m, we_reg_w, dm2reg_w, md_busy
  );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// Pipelined MIPS control unit: D-stage decode, E/M/W control registers and
// multi-cycle MULT/DIV busy sequencing with a stall request for the hazard unit.
module pipe_ctrl_unit #(
  parameter int unsigned MULT_CYCLES = 4,
  parameter int unsigned DIV_CYCLES  = 16,
  parameter int unsigned CNT_W       = 5
) (
  input logic             clk,
  input logic             rst_n,
  pipe_ctrl_unit_if.slave bus
);
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;

  localparam logic [1:0] MD_MULT  = 2'b01;
  localparam logic [1:0] MD_MULTU = 2'b10;
  localparam logic [1:0] MD_DIV   = 2'b11;
  localparam logic [1:0] MF_LO    = 2'b01;
  localparam logic [1:0] MF_HI    = 2'b10;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       zext;
    logic [3:0] alu_ctrl;
    logic       shamt_sel;
    logic [1:0] md_op;
    logic       md_start;
    logic       jal;
    logic [1:0] mf_hilo;
    logic       we_dm;
    logic       we_reg;
    logic       dm2reg;
  } ctrl_t;

  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             unused_instr;
  ctrl_t            ctrl_c;
  ctrl_t            ctrl_e;
  logic             branch_c, bne_c, jump_c, jr_c, illegal_c;
  logic             md_in_d_c, mf_in_d_c, md_stall_c;
  logic             we_dm_m, we_reg_m, dm2reg_m, we_reg_w, dm2reg_w;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt_c;
  logic             md_busy_q;

  assign opcode       = bus.instr_d[31:26];
  assign funct        = bus.instr_d[5:0];
  assign unused_instr = ^bus.instr_d[25:6];

  // Decode of the D-stage instruction; unsupported encodings leave the bundle all-zero.
  always_comb begin : decode
    ctrl_c    = '0;
    branch_c  = 1'b0;
    bne_c     = 1'b0;
    jump_c    = 1'b0;
    jr_c      = 1'b0;
    illegal_c = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_ADDU: begin ctrl_c.reg_dst = 1'b1; ctrl_c.we_reg = 1'b1; ctrl_c.alu_ctrl = ALU_ADD; end
          FN_SUB, FN_SUBU: begin ctrl_c.reg_dst = 1'b1; ctrl_c.we_reg = 1'b1; ctrl_c.alu_ctrl = ALU_SUB; end
          FN_AND:  begin ctrl_c.reg_dst = 1'b1; ctrl_c.we_reg = 1'b1; ctrl_c.alu_ctrl = ALU_AND; end
          FN_OR:   begin ctrl_c.reg_dst = 1'b1; ctrl_c.we_reg = 1'b1; ctrl_c.alu_ctrl = ALU_OR;  end
          FN_SLT:  begin ctrl_c.reg_dst = 1'b1; ctrl_c.we_reg = 1'b1; ctrl_c.alu_ctrl = ALU_SLT; end
          FN_SLL: begin
            ctrl_c.reg_dst = 1'b1; ctrl_c.we_reg = 1'b1; ctrl_c.shamt_sel = 1'b1; ctrl_c.alu_ctrl = ALU_SLL;
          end
          FN_SRL: begin
            ctrl_c.reg_dst = 1'b1; ctrl_c.we_reg = 1'b1; ctrl_c.shamt_sel = 1'b1; ctrl_c.alu_ctrl = ALU_SRL;
          end
          FN_JR:           jr_c = 1'b1;
          FN_MULT:         begin ctrl_c.md_op = MD_MULT;  ctrl_c.md_start = 1'b1; end
          FN_MULTU:        begin ctrl_c.md_op = MD_MULTU; ctrl_c.md_start = 1'b1; end
          FN_DIV, FN_DIVU: begin ctrl_c.md_op = MD_DIV;   ctrl_c.md_start = 1'b1; end
          FN_MFHI: begin ctrl_c.reg_dst = 1'b1; ctrl_c.we_reg = 1'b1; ctrl_c.mf_hilo = MF_HI; end
          FN_MFLO: begin ctrl_c.reg_dst = 1'b1; ctrl_c.we_reg = 1'b1; ctrl_c.mf_hilo = MF_LO; end
          default: illegal_c = 1'b1;
        endcase
      end
      OP_LW: begin
        ctrl_c.alu_src = 1'b1; ctrl_c.alu_ctrl = ALU_ADD; ctrl_c.we_reg = 1'b1; ctrl_c.dm2reg = 1'b1;
      end
      OP_SW:   begin ctrl_c.alu_src = 1'b1; ctrl_c.alu_ctrl = ALU_ADD; ctrl_c.we_dm = 1'b1; end
      OP_BEQ:  branch_c = 1'b1;
      OP_BNE:  bne_c = 1'b1;
      OP_ADDI: begin ctrl_c.alu_src = 1'b1; ctrl_c.alu_ctrl = ALU_ADD; ctrl_c.we_reg = 1'b1; end
      OP_SLTI: begin ctrl_c.alu_src = 1'b1; ctrl_c.alu_ctrl = ALU_SLT; ctrl_c.we_reg = 1'b1; end
      OP_ANDI: begin
        ctrl_c.alu_src = 1'b1; ctrl_c.zext = 1'b1; ctrl_c.alu_ctrl = ALU_AND; ctrl_c.we_reg = 1'b1;
      end
      OP_ORI: begin
        ctrl_c.alu_src = 1'b1; ctrl_c.zext = 1'b1; ctrl_c.alu_ctrl = ALU_OR; ctrl_c.we_reg = 1'b1;
      end
      OP_J:    jump_c = 1'b1;
      OP_JAL:  begin jump_c = 1'b1; ctrl_c.jal = 1'b1; ctrl_c.we_reg = 1'b1; end
      default: illegal_c = 1'b1;
    endcase
  end

  assign md_in_d_c  = ctrl_c.md_start;
  assign mf_in_d_c  = (ctrl_c.mf_hilo != 2'b00);
  assign md_stall_c = (md_busy_q && (md_in_d_c || mf_in_d_c)) || (ctrl_e.md_start && mf_in_d_c);

  // Busy counter: an issuing op reloads (new load wins), otherwise count down to zero.
  always_comb begin : cnt_next
    cnt_nxt_c = cnt;
    if (ctrl_c.md_start && !bus.flush_e) begin
      cnt_nxt_c = (ctrl_c.md_op == MD_DIV) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (cnt != '0) begin
      cnt_nxt_c = cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : stage_regs
    if (!rst_n) begin
      ctrl_e    <= '0;
      we_dm_m   <= 1'b0;
      we_reg_m  <= 1'b0;
      dm2reg_m  <= 1'b0;
      we_reg_w  <= 1'b0;
      dm2reg_w  <= 1'b0;
      cnt       <= '0;
      md_busy_q <= 1'b0;
    end else begin
      if (bus.flush_e) begin
        ctrl_e <= '0;
      end else begin
        ctrl_e <= ctrl_c;
      end
      we_dm_m   <= ctrl_e.we_dm;
      we_reg_m  <= ctrl_e.we_reg;
      dm2reg_m  <= ctrl_e.dm2reg;
      we_reg_w  <= we_reg_m;
      dm2reg_w  <= dm2reg_m;
      cnt       <= cnt_nxt_c;
      md_busy_q <= (cnt_nxt_c != '0);
    end
  end

  assign bus.branch_d    = branch_c;
  assign bus.bne_d       = bne_c;
  assign bus.jump_d      = jump_c;
  assign bus.jr_d        = jr_c;
  assign bus.illegal_d   = illegal_c;
  assign bus.md_stall_d  = md_stall_c;
  assign bus.reg_dst_e   = ctrl_e.reg_dst;
  assign bus.alu_src_e   = ctrl_e.alu_src;
  assign bus.zext_e      = ctrl_e.zext;
  assign bus.alu_ctrl_e  = ctrl_e.alu_ctrl;
  assign bus.shamt_sel_e = ctrl_e.shamt_sel;
  assign bus.md_op_e     = ctrl_e.md_op;
  assign bus.md_start_e  = ctrl_e.md_start;
  assign bus.jal_e       = ctrl_e.jal;
  assign bus.mf_hilo_e   = ctrl_e.mf_hilo;
  assign bus.we_dm_m     = we_dm_m;
  assign bus.we_reg_m    = we_reg_m;
  assign bus.dm2reg_m    = dm2reg_m;
  assign bus.we_reg_w    = we_reg_w;
  assign bus.dm2reg_w    = dm2reg_w;
  assign bus.md_busy     = md_busy_q;
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: directed scenarios plus randomized instruction stream
// checked each cycle against an instruction-level model of the control pipeline.
module tb_pipe_ctrl_unit;
  localparam int unsigned MULT_N = 4;
  localparam int unsigned DIV_N  = 16;
  localparam int          NKIND  = 26;

  typedef enum int {
    K_ADD, K_ADDU, K_SUB, K_SUBU, K_AND, K_OR, K_SLT, K_SLL, K_SRL, K_JR,
    K_MULT, K_MULTU, K_DIV, K_DIVU, K_MFHI, K_MFLO,
    K_LW, K_SW, K_BEQ, K_BNE, K_ADDI, K_ANDI, K_ORI, K_SLTI, K_J, K_JAL, K_ILL
  } kind_t;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       zext;
    logic [3:0] alu_ctrl;
    logic       shamt_sel;
    logic [1:0] md_op;
    logic       md_start;
    logic       jal;
    logic [1:0] mf_hilo;
    logic       we_dm;
    logic       we_reg;
    logic       dm2reg;
  } ebun_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  pipe_ctrl_unit_if bus ();

  pipe_ctrl_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(5)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int    total = 0;
  int    bad   = 0;
  ebun_t pipe_m [3];
  int    cyc = 0;
  int    md_issue = 0;
  int    md_len_m = 0;
  logic  last_stall, last_busy;

  // {opcode, funct}; funct is meaningful only for opcode 0
  function automatic logic [11:0] code_of(kind_t k);
    case (k)
      K_ADD:   return {6'h00, 6'h20};
      K_ADDU:  return {6'h00, 6'h21};
      K_SUB:   return {6'h00, 6'h22};
      K_SUBU:  return {6'h00, 6'h23};
      K_AND:   return {6'h00, 6'h24};
      K_OR:    return {6'h00, 6'h25};
      K_SLT:   return {6'h00, 6'h2A};
      K_SLL:   return {6'h00, 6'h00};
      K_SRL:   return {6'h00, 6'h02};
      K_JR:    return {6'h00, 6'h08};
      K_MULT:  return {6'h00, 6'h18};
      K_MULTU: return {6'h00, 6'h19};
      K_DIV:   return {6'h00, 6'h1A};
      K_DIVU:  return {6'h00, 6'h1B};
      K_MFHI:  return {6'h00, 6'h10};
      K_MFLO:  return {6'h00, 6'h12};
      K_LW:    return {6'h23, 6'h00};
      K_SW:    return {6'h2B, 6'h00};
      K_BEQ:   return {6'h04, 6'h00};
      K_BNE:   return {6'h05, 6'h00};
      K_ADDI:  return {6'h08, 6'h00};
      K_ANDI:  return {6'h0C, 6'h00};
      K_ORI:   return {6'h0D, 6'h00};
      K_SLTI:  return {6'h0A, 6'h00};
      K_J:     return {6'h02, 6'h00};
      K_JAL:   return {6'h03, 6'h00};
      default: return {6'h3F, 6'h3F};
    endcase
  endfunction

  function automatic kind_t classify(logic [31:0] x);
    logic [11:0] c;
    for (int i = 0; i < NKIND; i++) begin
      c = code_of(kind_t'(i));
      if (x[31:26] == c[11:6] && (c[11:6] != 6'h00 || x[5:0] == c[5:0])) return kind_t'(i);
    end
    return K_ILL;
  endfunction

  function automatic logic [31:0] make_instr(kind_t k);
    logic [31:0] r;
    logic [11:0] c;
    r = $urandom;
    c = code_of(k);
    return {c[11:6], r[25:6], (c[11:6] == 6'h00) ? c[5:0] : r[5:0]};
  endfunction

  function automatic logic [31:0] make_illegal();
    logic [31:0] x;
    for (int t = 0; t < 64; t++) begin
      x = $urandom;
      if ($urandom_range(0, 1) == 0) x[31:26] = 6'h00;
      if (classify(x) == K_ILL) return x;
    end
    return 32'hFC00_0000;
  endfunction

  // Control bundle each instruction must carry, written per instruction.
  function automatic ebun_t bundle_of(kind_t k);
    ebun_t b;
    b = '0;
    case (k)
      K_ADD, K_ADDU: begin b.reg_dst = 1; b.we_reg = 1; b.alu_ctrl = 4'b0010; end
      K_SUB, K_SUBU: begin b.reg_dst = 1; b.we_reg = 1; b.alu_ctrl = 4'b0110; end
      K_AND:   begin b.reg_dst = 1; b.we_reg = 1; b.alu_ctrl = 4'b0000; end
      K_OR:    begin b.reg_dst = 1; b.we_reg = 1; b.alu_ctrl = 4'b0001; end
      K_SLT:   begin b.reg_dst = 1; b.we_reg = 1; b.alu_ctrl = 4'b0111; end
      K_SLL:   begin b.reg_dst = 1; b.we_reg = 1; b.shamt_sel = 1; b.alu_ctrl = 4'b1000; end
      K_SRL:   begin b.reg_dst = 1; b.we_reg = 1; b.shamt_sel = 1; b.alu_ctrl = 4'b1001; end
      K_MULT:  begin b.md_op = 2'b01; b.md_start = 1; end
      K_MULTU: begin b.md_op = 2'b10; b.md_start = 1; end
      K_DIV, K_DIVU: begin b.md_op = 2'b11; b.md_start = 1; end
      K_MFHI:  begin b.reg_dst = 1; b.we_reg = 1; b.mf_hilo = 2'b10; end
      K_MFLO:  begin b.reg_dst = 1; b.we_reg = 1; b.mf_hilo = 2'b01; end
      K_LW:    begin b.alu_src = 1; b.alu_ctrl = 4'b0010; b.we_reg = 1; b.dm2reg = 1; end
      K_SW:    begin b.alu_src = 1; b.alu_ctrl = 4'b0010; b.we_dm = 1; end
      K_ADDI:  begin b.alu_src = 1; b.alu_ctrl = 4'b0010; b.we_reg = 1; end
      K_ANDI:  begin b.alu_src = 1; b.zext = 1; b.alu_ctrl = 4'b0000; b.we_reg = 1; end
      K_ORI:   begin b.alu_src = 1; b.zext = 1; b.alu_ctrl = 4'b0001; b.we_reg = 1; end
      K_SLTI:  begin b.alu_src = 1; b.alu_ctrl = 4'b0111; b.we_reg = 1; end
      K_JAL:   begin b.jal = 1; b.we_reg = 1; end
      default: b = '0;
    endcase
    return b;
  endfunction

  function automatic logic [4:0] dflags(kind_t k);
    return {k == K_BEQ, k == K_BNE, (k == K_J) || (k == K_JAL), k == K_JR, k == K_ILL};
  endfunction

  function automatic logic is_md(kind_t k);
    return (k == K_MULT) || (k == K_MULTU) || (k == K_DIV) || (k == K_DIVU);
  endfunction

  function automatic logic is_mf(kind_t k);
    return (k == K_MFHI) || (k == K_MFLO);
  endfunction

  function automatic logic model_busy();
    return (cyc - md_issue) < md_len_m;
  endfunction

  function automatic logic model_stall(kind_t k);
    return (model_busy() && (is_md(k) || is_mf(k))) || (pipe_m[0].md_start && is_mf(k));
  endfunction

  task automatic model_edge(input logic [31:0] ins, input logic fl);
    kind_t k;
    k = classify(ins);
    pipe_m[2] = pipe_m[1];
    pipe_m[1] = pipe_m[0];
    pipe_m[0] = fl ? ebun_t'('0) : bundle_of(k);
    cyc++;
    if (!fl && is_md(k)) begin
      md_issue = cyc;
      md_len_m = ((k == K_DIV) || (k == K_DIVU)) ? int'(DIV_N) : int'(MULT_N);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) pipe_m[i] = '0;
    md_len_m = 0;
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
    end
  endtask

  function automatic logic [13:0] dut_e_view();
    return {bus.reg_dst_e, bus.alu_src_e, bus.zext_e, bus.alu_ctrl_e, bus.shamt_sel_e,
            bus.md_op_e, bus.md_start_e, bus.jal_e, bus.mf_hilo_e};
  endfunction

  task automatic check_all();
    kind_t k;
    k = classify(bus.instr_d);
    cmp("d_flags", 32'({bus.branch_d, bus.bne_d, bus.jump_d, bus.jr_d, bus.illegal_d}), 32'(dflags(k)));
    cmp("md_stall_d", 32'(bus.md_stall_d), 32'(model_stall(k)));
    cmp("e_bundle", 32'(dut_e_view()), 32'(14'(pipe_m[0] >> 3)));
    cmp("m_stage", 32'({bus.we_dm_m, bus.we_reg_m, bus.dm2reg_m}), 32'(pipe_m[1][2:0]));
    cmp("w_stage", 32'({bus.we_reg_w, bus.dm2reg_w}), 32'(pipe_m[2][1:0]));
    cmp("md_busy", 32'(bus.md_busy), 32'(model_busy()));
  endtask

  // One pipeline cycle: drive at negedge, check, then advance the model at posedge.
  task automatic cycle(input logic [31:0] ins, input logic fl);
    @(negedge clk);
    bus.instr_d = ins;
    bus.flush_e = fl;
    #1;
    check_all();
    last_stall = bus.md_stall_d;
    last_busy  = bus.md_busy;
    @(posedge clk);
    model_edge(ins, fl);
  endtask

  // Acts as the hazard unit: flush E whenever the model says D must stall.
  task automatic hz_cycle(input logic [31:0] ins);
    cycle(ins, model_stall(classify(ins)));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] i_add, i_lw, i_ori, i_bne, i_beq, i_mult, i_mflo, i_div, i_divu, i_mfhi, i_ill, ins;
    int   nst, nbusy;
    logic done, held, fl;

    i_add  = make_instr(K_ADD);
    i_lw   = make_instr(K_LW);
    i_ori  = make_instr(K_ORI);
    i_bne  = make_instr(K_BNE);
    i_beq  = make_instr(K_BEQ);
    i_mult = make_instr(K_MULT);
    i_mflo = make_instr(K_MFLO);
    i_div  = make_instr(K_DIV);
    i_divu = make_instr(K_DIVU);
    i_mfhi = make_instr(K_MFHI);
    i_ill  = {6'h3F, 26'($urandom)};
    model_reset();

    // Reset holds everything registered at zero while ADD sits in D.
    bus.instr_d = i_add;
    bus.flush_e = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check_all();
    cmp("rst_reg_dst_e", 32'(bus.reg_dst_e), 32'd0);
    cmp("rst_alu_ctrl_e", 32'(bus.alu_ctrl_e), 32'd0);
    cmp("rst_we_reg_m", 32'(bus.we_reg_m), 32'd0);
    cmp("rst_md_busy", 32'(bus.md_busy), 32'd0);
    #1 rst_n = 1'b1;
    cycle(i_add, 1'b0);
    #2;
    cmp("add_alu_ctrl_e", 32'(bus.alu_ctrl_e), 32'b0010);
    cmp("add_reg_dst_e", 32'(bus.reg_dst_e), 32'd1);
    cmp("add_we_reg_m_early", 32'(bus.we_reg_m), 32'd0);
    cycle(i_beq, 1'b0);
    #2 cmp("add_we_reg_m", 32'(bus.we_reg_m), 32'd1);
    cycle(i_beq, 1'b0);
    #2 cmp("add_we_reg_w", 32'(bus.we_reg_w), 32'd1);

    // Sweep every supported instruction, then pin a few bundles by hand.
    for (int k = 0; k < NKIND; k++) hz_cycle(make_instr(kind_t'(k)));
    repeat (20) cycle(i_beq, 1'b0);
    cycle(i_lw, 1'b0);
    #2 cmp("lw_alu_src_e", 32'(bus.alu_src_e), 32'd1);
    cycle(i_beq, 1'b0);
    #2;
    cmp("lw_dm2reg_m", 32'(bus.dm2reg_m), 32'd1);
    cmp("lw_we_reg_m", 32'(bus.we_reg_m), 32'd1);
    cycle(i_ori, 1'b0);
    #2;
    cmp("ori_zext_e", 32'(bus.zext_e), 32'd1);
    cmp("ori_alu_ctrl_e", 32'(bus.alu_ctrl_e), 32'b0001);
    cycle(i_bne, 1'b0);
    #2;
    cmp("bne_d", 32'(bus.bne_d), 32'd1);
    cmp("bne_e_zero", 32'(dut_e_view()), 32'd0);
    cycle(i_ill, 1'b0);
    #2;
    cmp("ill_illegal_d", 32'(bus.illegal_d), 32'd1);
    cmp("ill_e_zero", 32'(dut_e_view()), 32'd0);

    // Bubble: flushed LW never reaches E, M or W.
    cycle(i_lw, 1'b1);
    #2 cmp("bubble_e", 32'(dut_e_view()), 32'd0);
    cycle(i_beq, 1'b0);
    #2 cmp("bubble_m", 32'({bus.we_dm_m, bus.we_reg_m, bus.dm2reg_m}), 32'd0);
    cycle(i_beq, 1'b0);
    #2 cmp("bubble_w", 32'({bus.we_reg_w, bus.dm2reg_w}), 32'd0);

    // MULT then MFLO waiting for HI/LO.
    cycle(i_mult, 1'b0);
    #2;
    cmp("mult_start_e", 32'(bus.md_start_e), 32'd1);
    cmp("mult_md_op_e", 32'(bus.md_op_e), 32'b01);
    nst = 0; nbusy = 0; done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      hz_cycle(i_mflo);
      if (last_busy) nbusy++;
      if (last_stall) nst++; else done = 1'b1;
    end
    cmp("mflo_release", 32'(done), 32'd1);
    cmp("mult_stall_cycles", 32'(nst), 32'd4);
    cmp("mult_busy_cycles", 32'(nbusy), 32'd4);
    #2 cmp("mflo_mf_hilo_e", 32'(bus.mf_hilo_e), 32'b01);

    // DIV followed immediately by DIVU.
    cycle(i_div, 1'b0);
    #2;
    cmp("div_start_e", 32'(bus.md_start_e), 32'd1);
    cmp("div_md_op_e", 32'(bus.md_op_e), 32'b11);
    nst = 0; done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      hz_cycle(i_divu);
      if (last_stall) nst++; else done = 1'b1;
    end
    cmp("divu_release", 32'(done), 32'd1);
    cmp("divu_stall_cycles", 32'(nst), 32'(DIV_N));
    #2;
    cmp("divu_start_e", 32'(bus.md_start_e), 32'd1);
    cmp("divu_md_op_e", 32'(bus.md_op_e), 32'b11);

    // Async reset with DIVU 7 cycles from completion and MFHI stalled in D.
    repeat (9) hz_cycle(i_mfhi);
    #2;
    cmp("pre_rst_busy", 32'(bus.md_busy), 32'd1);
    cmp("pre_rst_stall", 32'(bus.md_stall_d), 32'd1);
    rst_n = 1'b0;
    #1;
    cmp("async_rst_busy", 32'(bus.md_busy), 32'd0);
    cmp("async_rst_stall", 32'(bus.md_stall_d), 32'd0);
    model_reset();
    check_all();
    #1 rst_n = 1'b1;

    // Random instruction stream with hazard-unit behaviour and spare flushes.
    held = 1'b0;
    ins  = i_mfhi;
    for (int n = 0; n < 3000; n++) begin
      if (!held) begin
        case ($urandom_range(0, 19))
          0:       ins = 32'h0;
          1, 2:    ins = make_illegal();
          default: ins = make_instr(kind_t'($urandom_range(0, NKIND - 1)));
        endcase
      end
      held = model_stall(classify(ins));
      fl   = held | ($urandom_range(0, 7) == 0);
      cycle(ins, fl);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
